// File: rtl/xiphos_alu_pkg.sv
// Shared types and CTRL encodings for the Hack-style ALU stage.
package xiphos_alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  // One registered result: value plus its flags.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] dat;
    logic                 zr;
    logic                 ng;
  } alu_res_t;

  localparam alu_ctrl_t ALU_ZERO    = 6'b101010;
  localparam alu_ctrl_t ALU_ONE     = 6'b111111;
  localparam alu_ctrl_t ALU_NEG1    = 6'b111010;
  localparam alu_ctrl_t ALU_X       = 6'b001100;
  localparam alu_ctrl_t ALU_Y       = 6'b110000;
  localparam alu_ctrl_t ALU_NOTX    = 6'b001101;
  localparam alu_ctrl_t ALU_XPLUSY  = 6'b000010;
  localparam alu_ctrl_t ALU_XANDY   = 6'b000000;
  localparam alu_ctrl_t ALU_XMINUSY = 6'b010011;

endpackage

// File: rtl/alu16_comb.sv
// Hack ALU function: operand zero/negate, AND or ADD, output negate, flags.
// Combinational, no latency; no flow control.
module alu16_comb
  import xiphos_alu_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  alu_ctrl_t   ctrl,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1, x2, y1, y2;
  logic [15:0] and_r, sum_r, r;

  assign x1 = ctrl.zx ? 16'h0000 : x;
  assign x2 = ctrl.nx ? ~x1 : x1;
  assign y1 = ctrl.zy ? 16'h0000 : y;
  assign y2 = ctrl.ny ? ~y1 : y1;

  AND16 u_and16 (
    .a   (x2),
    .b   (y2),
    .out (and_r)
  );

  // Carry out of bit 15 is intentionally dropped.
  assign sum_r = x2 + y2;
  assign r     = ctrl.f ? sum_r : and_r;
  assign out   = ctrl.no ? ~r : r;
  assign zr    = (out == 16'h0000);
  assign ng    = out[15];

endmodule

// File: rtl/and16.sv
// Bitwise 16-bit AND datapath.
// Combinational, no latency; no flow control.
module AND16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  assign out = a & b;

endmodule

// File: rtl/alu16_stage.sv
// Registered ALU execute stage with main + skid result registers.
// Latency 1 cycle from input transfer to OUT; IN_READY registered, drops only when both registers hold results.
module alu16_stage
  import xiphos_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [5:0]       CTRL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             ZR,
  output logic             NG
);

  if (WIDTH != ALU_WIDTH) begin : g_width_chk
    $error("alu16_stage supports WIDTH = 16 only");
  end

  alu_res_t  res, m_q, s_q, m_d, s_d;
  alu_ctrl_t ctrl;
  logic      m_vld, s_vld, m_vld_d, s_vld_d;
  logic      in_rdy, in_rdy_d;
  logic      in_fire, out_fire;

  assign ctrl = alu_ctrl_t'(CTRL);

  alu16_comb u_comb (
    .x    (X),
    .y    (Y),
    .ctrl (ctrl),
    .out  (res.dat),
    .zr   (res.zr),
    .ng   (res.ng)
  );

  assign in_fire  = IN_VALID && in_rdy;
  assign out_fire = m_vld && OUT_READY;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld;
    s_vld_d = s_vld;
    unique case ({m_vld, s_vld})
      2'b00: begin
        if (in_fire) begin
          m_d     = res;
          m_vld_d = 1'b1;
        end
      end
      2'b10: begin
        if (in_fire && out_fire) begin
          m_d = res;
        end else if (in_fire) begin
          s_d     = res;
          s_vld_d = 1'b1;
        end else if (out_fire) begin
          m_vld_d = 1'b0;
        end
      end
      2'b11: begin
        // IN_READY is low here, so only a drain can happen.
        if (out_fire) begin
          m_d     = s_q;
          s_vld_d = 1'b0;
        end
      end
      default: begin
        m_vld_d = 1'b0;
        s_vld_d = 1'b0;
      end
    endcase
    in_rdy_d = !(m_vld_d && s_vld_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_q    <= '0;
      s_q    <= '0;
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      in_rdy <= 1'b0;
    end else begin
      m_q    <= m_d;
      s_q    <= s_d;
      m_vld  <= m_vld_d;
      s_vld  <= s_vld_d;
      in_rdy <= in_rdy_d;
    end
  end

  assign IN_READY  = in_rdy;
  assign OUT_VALID = m_vld;
  assign OUT       = m_q.dat;
  assign ZR        = m_q.zr;
  assign NG        = m_q.ng;

endmodule

// File: tb/tb_alu16_stage.sv
// Bench for alu16_stage: directed cases plus random traffic against a queue-based model.
module tb_alu16_stage;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] X;
  logic [15:0] Y;
  logic [5:0]  CTRL;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT;
  logic        ZR;
  logic        NG;

  alu16_stage #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .X         (X),
    .Y         (Y),
    .CTRL      (CTRL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .ZR        (ZR),
    .NG        (NG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference function written straight from the arithmetic rules.
  function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    int a, b, r;
    a = c[5] ? 0 : int'(x);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(y);
    if (c[2]) b = 65535 - b;
    if (c[1]) r = (a + b) % 65536;
    else      r = a & b;
    if (c[0]) r = 65535 - r;
    return r[15:0];
  endfunction

  // Model: queue of results the stage currently holds (max two).
  logic [15:0] q[$];
  logic        rst_q = 1'b1;

  always @(posedge CLK) rst_q = RST;

  always @(negedge CLK) begin
    if (rst_q) begin
      chk("rst_ovld", OUT_VALID, 0);
      chk("rst_irdy", IN_READY, 0);
      chk("rst_out", OUT, 0);
      chk("rst_zr", ZR, 0);
      chk("rst_ng", NG, 0);
    end else begin
      chk("m_ovld", OUT_VALID, q.size() != 0);
      chk("m_irdy", IN_READY, q.size() < 2);
      if (OUT_VALID && q.size() != 0) begin
        chk("m_out", OUT, q[0]);
        chk("m_zr", ZR, q[0] == 16'h0000);
        chk("m_ng", NG, q[0][15]);
      end
    end
    if (RST) begin
      q.delete();
    end else begin
      if (OUT_VALID && OUT_READY && q.size() != 0) void'(q.pop_front());
      if (IN_VALID && IN_READY) q.push_back(ref_alu(X, Y, CTRL));
    end
  end

  task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                      input logic [5:0] c);
    @(posedge CLK);
    #1;
    IN_VALID = v;
    X        = x;
    Y        = y;
    CTRL     = c;
  endtask

  logic [5:0]  sw_c[6]  = '{6'b000000, 6'b000010, 6'b010011, 6'b101010, 6'b111111, 6'b111010};
  logic [15:0] sw_e[6]  = '{16'h0001, 16'h0008, 16'h0002, 16'h0000, 16'h0001, 16'hFFFF};
  logic [5:0]  named[9] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                            6'b001101, 6'b000010, 6'b000000, 6'b010011};

  initial begin
    logic pend;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    X = '0; Y = '0; CTRL = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_irdy", IN_READY, 1);

    // Function sweep, one-cycle latency each.
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0005, 16'h0003, sw_c[i]);
      step(1'b0, 16'h0005, 16'h0003, sw_c[i]);
      @(negedge CLK);
      chk("sweep_vld", OUT_VALID, 1);
      chk("sweep_out", OUT, sw_e[i]);
      chk("sweep_zr", ZR, sw_e[i] == 16'h0000);
      chk("sweep_ng", NG, sw_e[i][15]);
    end

    // Overflow boundaries.
    step(1'b1, 16'h7FFF, 16'h0001, 6'b000010);
    step(1'b1, 16'hFFFF, 16'h0001, 6'b000010);
    @(negedge CLK);
    chk("ovf_out", OUT, 16'h8000);
    chk("ovf_ng", NG, 1);
    chk("ovf_zr", ZR, 0);
    step(1'b0, 16'h0000, 16'h0000, 6'b000000);
    @(negedge CLK);
    chk("wrap_out", OUT, 16'h0000);
    chk("wrap_zr", ZR, 1);
    chk("wrap_ng", NG, 0);

    // Backpressure: two accepted, third held.
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    step(1'b1, 16'd1, 16'd1, 6'b000010);
    step(1'b1, 16'd2, 16'd2, 6'b000010);
    step(1'b1, 16'd3, 16'd3, 6'b000010);
    @(negedge CLK);
    chk("bp_irdy", IN_READY, 0);
    chk("bp_first", OUT, 16'h0002);
    @(posedge CLK);
    #1 OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_seq0", OUT, 16'h0002);
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_seq1_vld", OUT_VALID, 1);
    chk("bp_seq1", OUT, 16'h0004);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
    chk("bp_seq2_vld", OUT_VALID, 1);
    chk("bp_seq2", OUT, 16'h0006);
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_empty", OUT_VALID, 0);

    // Throughput: 16 back-to-back ops.
    for (int i = 0; i <= 16; i++) begin
      @(posedge CLK);
      #1;
      if (i < 16) begin
        IN_VALID = 1'b1; X = 16'(i * 3); Y = 16'(i + 100); CTRL = 6'b000010;
      end else begin
        IN_VALID = 1'b0;
      end
      @(negedge CLK);
      chk("tp_irdy", IN_READY, 1);
      if (i > 0) begin
        chk("tp_vld", OUT_VALID, 1);
        chk("tp_out", OUT, 32'((i - 1) * 4 + 100));
      end
    end

    // Reset while FULL.
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    step(1'b1, 16'd10, 16'd20, 6'b000010);
    step(1'b1, 16'd30, 16'd20, 6'b000010);
    @(posedge CLK);
    #1 begin IN_VALID = 1'b0; RST = 1'b1; end
    @(negedge CLK);
    chk("rm_full_irdy", IN_READY, 0);
    chk("rm_full_vld", OUT_VALID, 1);
    @(posedge CLK);
    #1 begin RST = 1'b0; OUT_READY = 1'b1; end
    @(negedge CLK);
    chk("rm_ovld", OUT_VALID, 0);
    chk("rm_out", OUT, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rm_irdy", IN_READY, 1);
    repeat (3) begin
      @(negedge CLK);
      chk("rm_no_stale", OUT_VALID, 0);
    end

    // Stability under stall with changing, unaccepted inputs.
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    step(1'b1, 16'h1234, 16'h00FF, 6'b000000);
    step(1'b0, 16'h1234, 16'h00FF, 6'b000000);
    for (int i = 0; i < 5; i++) begin
      X = 16'($urandom); Y = 16'($urandom); CTRL = 6'($urandom);
      @(negedge CLK);
      chk("stb_out", OUT, 16'h0034);
      chk("stb_zr", ZR, 0);
      chk("stb_ng", NG, 0);
      @(posedge CLK);
      #1;
    end
    OUT_READY = 1'b1;

    // Random traffic; upstream holds data while stalled.
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      pend = IN_VALID && !IN_READY;
      @(posedge CLK);
      #1;
      OUT_READY = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        IN_VALID = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 5))
          0:       X = 16'h7FFF;
          1:       X = 16'hFFFF;
          default: X = 16'($urandom);
        endcase
        Y    = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'($urandom);
        CTRL = ($urandom_range(0, 1) != 0) ? named[$urandom_range(0, 8)] : 6'($urandom);
      end
    end

    // Drain with a bounded wait.
    @(negedge CLK);
    pend = IN_VALID && !IN_READY;
    while (pend) begin
      @(negedge CLK);
      pend = IN_VALID && !IN_READY;
    end
    @(posedge CLK);
    #1 begin IN_VALID = 1'b0; OUT_READY = 1'b1; end
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge CLK);
    @(negedge CLK);
    chk("drain_empty", q.size(), 0);
    chk("drain_ovld", OUT_VALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
